// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: instruction and data ports share one downstream
// sram-like bus with a single outstanding transaction and data-first priority.
module sram_like_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic        rdata_unused_guard_n,
    input  logic [31:0] rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} stateT;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    stateT       stateReg;
    logic        ownerReg;      // 0 = inst, 1 = data
    logic [2:0]  starveCntReg;
    logic        grantData;
    logic [1:0]  addrOkVec;
    logic [1:0]  dataOkVec;

    // Data normally wins; inst takes over once data has been granted LIMIT times in a row.
    assign grantData = data_req && !(inst_req && (starveCntReg == LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            ownerReg     <= 1'b0;
            starveCntReg <= 3'd0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (data_req || inst_req) begin
                        ownerReg <= grantData;
                        stateReg <= ADDR;
                        if (grantData && inst_req)
                            starveCntReg <= (starveCntReg == LIMIT) ? LIMIT : starveCntReg + 3'd1;
                        else
                            starveCntReg <= 3'd0;
                    end
                end
                ADDR:    if (addr_ok) stateReg <= DATA;
                DATA:    if (data_ok) stateReg <= IDLE;
                default: stateReg <= IDLE;
            endcase
        end
    end

    // Handshake strobes go only to the current owner and only in the matching phase.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            assign addrOkVec[gi] = (stateReg == ADDR) && (ownerReg == 1'(gi)) && addr_ok;
            assign dataOkVec[gi] = (stateReg == DATA) && (ownerReg == 1'(gi)) && data_ok;
        end
    endgenerate

    assign inst_addr_ok = addrOkVec[0];
    assign data_addr_ok = addrOkVec[1];
    assign inst_data_ok = dataOkVec[0];
    assign data_data_ok = dataOkVec[1];

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    assign req   = (stateReg == ADDR);
    assign busy  = (stateReg != IDLE);
    assign wr    = ownerReg ? data_wr    : inst_wr;
    assign size  = ownerReg ? data_size  : inst_size;
    assign addr  = ownerReg ? data_addr  : inst_addr;
    assign wdata = ownerReg ? data_wdata : inst_wdata;

    logic unusedGuard;
    assign unusedGuard = rdata_unused_guard_n;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-phase reference model.
module tb_sram_like_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        req, wr, addr_ok, data_ok, busy;
    logic [31:0] addr, wdata, rdata;

    always #5 clk = ~clk;

    sram_like_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata_unused_guard_n(1'b0),
        .rdata(rdata), .busy(busy)
    );

    int vecCount  = 0;
    int missCount = 0;

    // Reference model: phase of the single outstanding transaction (0 idle, 1 address, 2 data).
    int mPhase  = 0;
    bit mOwner  = 0;
    int mStarve = 0;

    logic snapReq, snapBusy, snapIAok, snapDAok, snapIDok, snapDDok, snapWr;
    logic [31:0] snapAddr, snapWdata, snapIRdata;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clearInputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        addr_ok = 0; data_ok = 0; rdata = 0;
    endtask

    // Inputs are already driven; check outputs mid-cycle, then step the model across the edge.
    task automatic doCycle();
        bit pickInst;
        int nPhase, nStarve;
        bit nOwner;
        #1;
        checkEq("req",   req,   mPhase == 1);
        checkEq("busy",  busy,  mPhase != 0);
        checkEq("addr",  addr,  mOwner ? data_addr  : inst_addr);
        checkEq("wdata", wdata, mOwner ? data_wdata : inst_wdata);
        checkEq("wrsz",  {wr, size}, mOwner ? {data_wr, data_size} : {inst_wr, inst_size});
        checkEq("oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                {mPhase == 1 && !mOwner && addr_ok, mPhase == 1 && mOwner && addr_ok,
                 mPhase == 2 && !mOwner && data_ok, mPhase == 2 && mOwner && data_ok});
        checkEq("rdata", {inst_rdata ^ rdata} | {data_rdata ^ rdata}, 32'd0);
        snapReq = req; snapBusy = busy; snapIAok = inst_addr_ok; snapDAok = data_addr_ok;
        snapIDok = inst_data_ok; snapDDok = data_data_ok; snapWr = wr;
        snapAddr = addr; snapWdata = wdata; snapIRdata = inst_rdata;

        nPhase = mPhase; nOwner = mOwner; nStarve = mStarve;
        if (rst) begin
            nPhase = 0; nOwner = 0; nStarve = 0;
        end else if (mPhase == 0) begin
            if (inst_req || data_req) begin
                pickInst = inst_req && (!data_req || mStarve == LIMIT);
                nOwner   = !pickInst;
                nStarve  = (!pickInst && inst_req) ? ((mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1) : 0;
                nPhase   = 1;
            end
        end else if (mPhase == 1) begin
            if (addr_ok) nPhase = 2;
        end else if (data_ok) begin
            nPhase = 0;
        end
        @(posedge clk);
        #1;
        mPhase = nPhase; mOwner = nOwner; mStarve = nStarve;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        doCycle();
        rst = 0;
    endtask

    initial begin
        bit grants[$];
        bit expGrants[6] = '{1, 1, 1, 1, 0, 1};
        logic [31:0] stallAddr;

        clearInputs();
        rst = 1;
        @(posedge clk);
        #1;
        doReset();
        checkEq("rst_req",  snapReq,  0);
        checkEq("rst_busy", snapBusy, 0);

        // Single instruction read
        inst_req = 1; inst_addr = 32'hBFC0_0000;
        doCycle(); checkEq("rd_c0_req", snapReq, 0);
        doCycle(); checkEq("rd_c1_req", snapReq, 1); checkEq("rd_c1_addr", snapAddr, 32'hBFC0_0000);
        addr_ok = 1;
        doCycle(); checkEq("rd_c2_iaok", snapIAok, 1); checkEq("rd_c2_req", snapReq, 1);
        inst_req = 0; addr_ok = 0;
        doCycle(); checkEq("rd_c3_req", snapReq, 0); checkEq("rd_c3_busy", snapBusy, 1);
        data_ok = 1; rdata = 32'h3C08_BFC0;
        doCycle(); checkEq("rd_c4_idok", snapIDok, 1); checkEq("rd_c4_rdata", snapIRdata, 32'h3C08_BFC0);
        checkEq("rd_c4_dside", {snapDAok, snapDDok}, 0);
        data_ok = 0;
        doCycle(); checkEq("rd_c5_busy", snapBusy, 0);

        // Simultaneous requests: data first, inst right after
        doReset();
        inst_req = 1; inst_addr = 32'h0000_0040;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
        addr_ok = 1; data_ok = 1;
        doCycle();
        doCycle(); checkEq("sim_daddr", snapAddr, 32'h8000_1000); checkEq("sim_dwdata", snapWdata, 32'h1234_5678);
        checkEq("sim_dwr", snapWr, 1); checkEq("sim_daok", snapDAok, 1);
        data_req = 0;
        doCycle(); checkEq("sim_ddok", snapDDok, 1);
        doCycle(); checkEq("sim_idle", snapReq, 0);
        doCycle(); checkEq("sim_iaddr", snapAddr, 32'h0000_0040); checkEq("sim_iaok", snapIAok, 1);
        inst_req = 0;
        doCycle(); doCycle();

        // Starvation: continuous traffic from both sides
        doReset();
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        data_addr = 32'hA000_0000; inst_addr = 32'hB000_0000;
        for (int c = 0; c < 18; c++) begin
            doCycle();
            if (snapDAok) grants.push_back(1'b1);
            if (snapIAok) grants.push_back(1'b0);
        end
        checkEq("starve_n", grants.size(), 6);
        for (int g = 0; g < 6 && g < grants.size(); g++)
            checkEq($sformatf("starve_g%0d", g), grants[g], expGrants[g]);

        // Stalled slave
        doReset();
        stallAddr = 32'h1FC0_0100;
        inst_req = 1; inst_addr = stallAddr;
        doCycle();
        for (int c = 0; c < 10; c++) begin
            data_addr = $urandom; data_req = 1'($urandom);
            doCycle();
            checkEq("stall_req", snapReq, 1); checkEq("stall_addr", snapAddr, stallAddr);
            checkEq("stall_busy", snapBusy, 1);
            checkEq("stall_oks", {snapIAok, snapDAok, snapIDok, snapDDok}, 0);
        end
        clearInputs(); addr_ok = 1;
        doCycle(); checkEq("stall_iaok", snapIAok, 1);
        addr_ok = 0; data_ok = 1;
        doCycle(); data_ok = 0;

        // Reset during DATA with data owner, late data_ok ignored
        doReset();
        data_req = 1; data_addr = 32'h8000_2000;
        doCycle();
        addr_ok = 1; doCycle(); checkEq("rstd_daok", snapDAok, 1);
        data_req = 0; addr_ok = 0;
        doCycle(); checkEq("rstd_busy", snapBusy, 1);
        rst = 1; doCycle(); rst = 0;
        data_ok = 1;
        doCycle(); checkEq("rstd_ddok", snapDDok, 0); checkEq("rstd_idle", snapBusy, 0);
        data_ok = 0;

        // Spurious handshakes
        data_ok = 1;
        doCycle(); checkEq("spur_idle_ok", {snapIAok, snapDAok, snapIDok, snapDDok}, 0);
        data_ok = 0;
        doCycle(); checkEq("spur_idle_busy", snapBusy, 0);
        inst_req = 1; doCycle();
        addr_ok = 1; doCycle();
        inst_req = 0;
        doCycle(); checkEq("spur_data_ok", {snapIAok, snapDAok, snapIDok, snapDDok}, 0);
        addr_ok = 0;
        doCycle(); checkEq("spur_data_busy", snapBusy, 1); checkEq("spur_data_req", snapReq, 0);
        data_ok = 1; doCycle(); data_ok = 0;

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            inst_req   = ($urandom_range(0, 9) < 6);
            data_req   = ($urandom_range(0, 9) < 6);
            inst_wr    = 1'($urandom);  data_wr   = 1'($urandom);
            inst_size  = 2'($urandom);  data_size = 2'($urandom);
            inst_addr  = $urandom;      data_addr = $urandom;
            inst_wdata = $urandom;      data_wdata = $urandom;
            addr_ok    = 1'($urandom);  data_ok   = 1'($urandom);
            rdata      = $urandom;
            doCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive data grants allowed while inst_req is pending; range 1..7.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst_req / inst_wr / inst_size  input  1/1/2  instruction-side sram-like request, write flag, size code.
REQ-005 inst_addr / inst_wdata  input  32/32  instruction-side address and write data.
REQ-006 inst_addr_ok / inst_data_ok  output  1/1  instruction-side address accept and data return.
REQ-007 inst_rdata  output  32  instruction-side read data.
REQ-008 data_req, data_wr, data_size[1:0], data_addr[31:0], data_wdata[31:0] (inputs) and data_addr_ok, data_data_ok, data_rdata[31:0] (outputs) are the data-side equivalents.
REQ-009 req / wr / size / addr / wdata  output  1/1/2/32/32  shared downstream sram-like request.
REQ-010 addr_ok / data_ok / rdata  input  1/1/32  shared downstream handshake and read data.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADDR, DATA; one transaction outstanding downstream at any time.
REQ-013 IDLE: if data_req or inst_req is high, the arbiter SHALL latch owner (0 = inst, 1 = data) and enter ADDR on the next edge; otherwise it stays in IDLE.
REQ-014 Priority: data wins when both request, except when starve_cnt == STARVE_LIMIT and inst_req is high, in which case inst wins.
REQ-015 starve_cnt (3 bits) SHALL increment on each data grant made while inst_req is high, saturate at STARVE_LIMIT, and clear to 0 on any inst grant or any data grant made with inst_req low.
REQ-016 ADDR: req SHALL be 1 and wr/size/addr/wdata SHALL be the owner's inputs (combinational mux on the registered owner); the non-owner's inputs SHALL not reach the bus.
REQ-017 ADDR: addr_ok SHALL be routed to the owner's *_addr_ok in the same cycle; the non-owner's *_addr_ok SHALL be 0; addr_ok = 1 moves the FSM to DATA.
REQ-018 DATA: req SHALL be 0; data_ok SHALL be routed to the owner's *_data_ok in the same cycle; data_ok = 1 moves the FSM to IDLE.
REQ-019 rdata SHALL drive both inst_rdata and data_rdata unconditionally; only the *_data_ok strobe qualifies it.
REQ-020 In IDLE and ADDR, data_ok SHALL be ignored; in IDLE and DATA, addr_ok SHALL be ignored; neither may create a *_ok pulse.
REQ-021 Grant latency: a request seen in IDLE at cycle N SHALL appear on req at cycle N+1; the minimum transaction occupancy is 3 cycles (IDLE, ADDR, DATA).
REQ-022 A requester that deasserts its *_req while in ADDR as owner is a protocol violation; the arbiter SHALL still hold req = 1 until addr_ok.
REQ-023 A request arriving in the same cycle data_ok returns SHALL be arbitrated in the following IDLE cycle, not in DATA.
REQ-024 busy SHALL be 1 in ADDR and DATA, and 0 in IDLE.

Reset
REQ-025 While rst = 1 at an edge: state = IDLE, owner = 0, starve_cnt = 0.
REQ-026 Output values while in IDLE after reset: req = 0, all *_addr_ok and *_data_ok = 0, busy = 0; wr/size/addr/wdata follow the inst inputs (owner = 0).
REQ-027 Reset mid-transaction (ADDR or DATA) SHALL abandon the transaction; a downstream data_ok arriving after reset SHALL be ignored per REQ-020.

Verification
REQ-028 Single inst read: inst_req = 1, inst_addr = 0xBFC00000; addr_ok at cycle 2, data_ok at cycle 4 with rdata = 0x3C08BFC0 -> req high cycles 1-2, inst_addr_ok pulse at cycle 2, inst_data_ok plus inst_rdata = 0x3C08BFC0 at cycle 4, data_* outputs remain 0.
REQ-029 Simultaneous requests: inst_req and data_req (wr = 1, addr = 0x80001000, wdata = 0x12345678) both rise at cycle 0 -> data transaction issued first with the bus carrying data fields; inst transaction issued immediately after data_data_ok.
REQ-030 Starvation: STARVE_LIMIT = 4, inst_req held high, data_req held high continuously -> exactly 4 data grants, then 1 inst grant, then starve_cnt = 0 and data again.
REQ-031 Stalled slave: addr_ok held 0 for 10 cycles in ADDR -> req, addr, and owner stable for all 10 cycles; no *_ok pulses; busy = 1 throughout.
REQ-032 Reset during DATA with owner = data; data_ok = 1 one cycle after rst releases -> data_data_ok stays 0, state IDLE, busy = 0.
REQ-033 Spurious handshake: data_ok = 1 in IDLE and addr_ok = 1 in DATA -> no *_ok output pulse and no state change.
